bht_update_unit: RTL and testbench
==================================

Name: bht_update_unit

Overview:
- Branch history table: 2^INDEX_W entries, each a 2-bit saturating counter.
- Fetch reads a prediction for lookup_pc each cycle.
- Updates come from the stage-3 pipeline outputs: is_branch drives upd_valid, and the carried bht_state drives upd_state. The resolved direction arrives on upd_taken.
- The block also keeps branch and mispredict statistics counters for performance debug.

Parameters:
- INDEX_W, 6, table index width; table depth = 2^INDEX_W.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  pipeline enable; table, counters and mispredict register change only when en=1.
- lookup_pc  in  32  fetch PC to predict.
- pred_state  out  2  counter value for lookup_pc; fetch carries this down the pipe.
- pred_taken  out  1  pred_state[1].
- upd_valid  in  1  a resolved branch is present (stage-3 is_branch).
- upd_pc  in  32  PC of the resolved branch.
- upd_state  in  2  counter value predicted with (stage-3 bht_state).
- upd_taken  in  1  actual branch outcome.
- mispredict  out  1  registered; 1 for one cycle after a mispredicted update.
- branch_cnt  out  CNT_W  number of accepted updates.
- mispredict_cnt  out  CNT_W  number of accepted mispredicted updates.

Behaviour:
- Index mapping: index = pc[INDEX_W+1:2]. PC bits [1:0] and bits above INDEX_W+1 are ignored; aliasing is allowed.
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Reset (async, rst=1):
  - every table entry = 2'b01;
  - mispredict = 0;
  - branch_cnt = 0, mispredict_cnt = 0.
  - Reset asserted mid-operation discards any in-flight update. Outputs take their reset values without waiting for a clock edge.
- Accepted update: upd_valid=1 and en=1 at a rising edge.
  - Without en, there are no table writes and no counter changes, and mispredict holds its value.
- Next counter value: computed from upd_state, not from the current table contents.
  - taken: min(upd_state+1, 3).
  - not taken: max(upd_state-1, 0).
  - Saturation holds at 11 when taken and at 00 when not taken.
- Write: the next counter value is written to entry index(upd_pc) at the edge of an accepted update.
- Mispredict detection: mispredict_now = upd_state[1] XOR upd_taken.
- Register updates on an accepted update:
  - mispredict <= mispredict_now.
  - branch_cnt += 1.
  - mispredict_cnt += mispredict_now.
  - If en=1 and upd_valid=0, mispredict <= 0.
- Counter overflow: both counters wrap modulo 2^CNT_W; no saturation and no sticky flag.
- Read path: pred_state is combinational from the table; there is no read latency.
- Read/update collision (write-first bypass): upd_valid=1, en=1 and index(lookup_pc)==index(upd_pc) in the same cycle.
  - pred_state shows the next counter value in that cycle, not the stored one.
  - Without en there is no bypass.
- Each cycle performs at most one write; there is no conflict between simultaneous events.
- Stalls: an update held across cycles with en=0 takes effect exactly once, at the first edge with en=1.
- upd_valid with an X upd_state is not allowed.

Test Plan:
- Reset: assert rst → pred_state=01 for lookup_pc 0x0, 0x4 and 0xFC; branch_cnt=0, mispredict_cnt=0, mispredict=0.
- Training:
  - 3 updates at upd_pc=0x40, taken=1, with upd_state fed back from pred_state → table goes 01→10→11→11 (saturates); pred_taken=1.
  - Counters: branch_cnt=3, mispredict_cnt=1 (the first update, predicted not-taken); mispredict pulses only after the first update.
- Bypass and aliasing:
  - lookup_pc=0x40 while updating 0x40 with upd_state=11, taken=0 → pred_state=10 in that same cycle.
  - lookup_pc=0x140 aliases to 0x40 with INDEX_W=6 → pred_state=10.
- en stall: hold upd_valid=1 with en=0 for 4 cycles, then en=1 for 1 cycle → exactly one table write; branch_cnt increments by 1; mispredict unchanged during the stall.
- Counter wrap: with CNT_W=4, apply 17 mispredicted updates → branch_cnt=1, mispredict_cnt=1.
- Async reset mid-update: assert rst between clock edges while upd_valid=1 → outputs reset immediately; the entry reads 01 after reset is released.

Source files
------------

// File: rtl/bht_update_unit.sv
// rtl/bht_update_unit.sv - branch history table of 2-bit saturating counters with update and statistics
// Combinational prediction read with write-first bypass; registered mispredict pulse and perf counters.
module bht_update_unit #(
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      lookup_pc,
  output logic [1:0]       pred_state,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [1:0]       upd_state,
  input  logic             upd_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [1:0]         r_table [DEPTH];
  logic               r_mispredict;
  logic [CNT_W-1:0]   r_branch_cnt;
  logic [CNT_W-1:0]   r_mispredict_cnt;

  logic [INDEX_W-1:0] w_lookup_idx;
  logic [INDEX_W-1:0] w_upd_idx;
  logic               w_accept;
  logic               w_mis_now;
  logic [1:0]         w_next_state;

  assign w_lookup_idx = lookup_pc[INDEX_W+1:2];
  assign w_upd_idx    = upd_pc[INDEX_W+1:2];
  assign w_accept     = en & upd_valid;
  assign w_mis_now    = upd_state[1] ^ upd_taken;

  // Next value derives from the state the branch was predicted with, not the live table.
  always_comb begin
    w_next_state = upd_state;
    if (upd_taken) begin
      if (upd_state != 2'b11) w_next_state = upd_state + 2'b01;
    end else begin
      if (upd_state != 2'b00) w_next_state = upd_state - 2'b01;
    end
  end

  always_comb begin
    pred_state = r_table[w_lookup_idx];
    if (w_accept && (w_lookup_idx == w_upd_idx)) pred_state = w_next_state;
  end

  assign pred_taken     = pred_state[1];
  assign mispredict     = r_mispredict;
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= 2'b01;
      r_mispredict     <= 1'b0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (en) begin
      if (upd_valid) begin
        r_table[w_upd_idx] <= w_next_state;
        r_mispredict       <= w_mis_now;
        r_branch_cnt       <= r_branch_cnt + 1'b1;
        r_mispredict_cnt   <= r_mispredict_cnt + {{(CNT_W-1){1'b0}}, w_mis_now};
      end else begin
        r_mispredict <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bht_update_unit.sv
// tb/tb_bht_update_unit.sv - scoreboard bench for bht_update_unit
// Expectations are queued when stimulus is driven and popped at the sampling point.
module tb_bht_update_unit;

  localparam int INDEX_W = 6;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [31:0]      lookup_pc;
  logic [1:0]       pred_state;
  logic             pred_taken;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [1:0]       upd_state;
  logic             upd_taken;
  logic             mispredict;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  bht_update_unit #(.INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .lookup_pc(lookup_pc),
    .pred_state(pred_state), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_state(upd_state), .upd_taken(upd_taken),
    .mispredict(mispredict), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q [$];
  int          n_vec  = 0;
  int          n_fail = 0;

  logic [1:0]       m_tbl [64];
  logic             m_mis;
  logic [CNT_W-1:0] m_bcnt;
  logic [CNT_W-1:0] m_mcnt;

  function automatic logic [1:0] sat_next(input logic [1:0] st, input logic tk);
    logic [1:0] r;
    case ({tk, st})
      3'b1_00: r = 2'b01;
      3'b1_01: r = 2'b10;
      3'b1_10: r = 2'b11;
      3'b1_11: r = 2'b11;
      3'b0_00: r = 2'b00;
      3'b0_01: r = 2'b00;
      3'b0_10: r = 2'b01;
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
    m_mis  = 1'b0;
    m_bcnt = '0;
    m_mcnt = '0;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic const_chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push(e);
    pop_chk(tag, obs);
  endtask

  task automatic chk_regs(input string tag);
    pop_chk({tag, ".mispredict"}, {31'b0, mispredict});
    pop_chk({tag, ".branch_cnt"}, {28'b0, branch_cnt});
    pop_chk({tag, ".mispredict_cnt"}, {28'b0, mispredict_cnt});
  endtask

  // One clock of stimulus: drive after negedge, check read path, then check registers after posedge.
  task automatic step(input string tag, input logic e, input logic v, input logic [31:0] pc,
                      input logic [1:0] st, input logic tk, input logic [31:0] lpc);
    logic [1:0] p;
    logic [5:0] li;
    logic [5:0] ui;
    @(negedge clk);
    en = e; upd_valid = v; upd_pc = pc; upd_state = st; upd_taken = tk; lookup_pc = lpc;
    li = lpc[7:2];
    ui = pc[7:2];
    p  = (e && v && li == ui) ? sat_next(st, tk) : m_tbl[li];
    push({30'b0, p});
    push({31'b0, p[1]});
    if (e) begin
      if (v) begin
        m_tbl[ui] = sat_next(st, tk);
        m_mis     = st[1] ^ tk;
        m_bcnt    = m_bcnt + 1'b1;
        m_mcnt    = m_mcnt + {3'b0, st[1] ^ tk};
      end else begin
        m_mis = 1'b0;
      end
    end
    push({31'b0, m_mis});
    push({28'b0, m_bcnt});
    push({28'b0, m_mcnt});
    #1;
    pop_chk({tag, ".pred_state"}, {30'b0, pred_state});
    pop_chk({tag, ".pred_taken"}, {31'b0, pred_taken});
    @(posedge clk);
    #1;
    chk_regs(tag);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] fb;
    rst = 1'b1; en = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_state = 2'b01;
    upd_taken = 1'b0; lookup_pc = 32'h0;
    model_reset();

    // Reset state
    #1;
    const_chk("rst.pred_0x0", {30'b0, pred_state}, 32'h1);
    lookup_pc = 32'h4; #1;
    const_chk("rst.pred_0x4", {30'b0, pred_state}, 32'h1);
    lookup_pc = 32'hFC; #1;
    const_chk("rst.pred_0xFC", {30'b0, pred_state}, 32'h1);
    const_chk("rst.branch_cnt", {28'b0, branch_cnt}, 32'h0);
    const_chk("rst.mispredict_cnt", {28'b0, mispredict_cnt}, 32'h0);
    const_chk("rst.mispredict", {31'b0, mispredict}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Training at 0x40 with state fed back from the prediction
    for (int i = 0; i < 3; i++) begin
      fb = m_tbl[6'h10];
      step($sformatf("train%0d", i), 1'b1, 1'b1, 32'h40, fb, 1'b1, 32'h0);
      if (i == 0) const_chk("train0.mis_pulse", {31'b0, mispredict}, 32'h1);
      if (i == 1) const_chk("train1.mis_clear", {31'b0, mispredict}, 32'h0);
    end
    step("train.read", 1'b1, 1'b0, 32'h0, 2'b01, 1'b0, 32'h40);
    const_chk("train.table", {30'b0, pred_state}, 32'h3);
    const_chk("train.pred_taken", {31'b0, pred_taken}, 32'h1);
    const_chk("train.branch_cnt", {28'b0, branch_cnt}, 32'h3);
    const_chk("train.mispredict_cnt", {28'b0, mispredict_cnt}, 32'h1);

    // Bypass: same-cycle write-first read, then an aliased PC
    @(negedge clk);
    en = 1'b1; upd_valid = 1'b1; upd_pc = 32'h40; upd_state = 2'b11; upd_taken = 1'b0;
    lookup_pc = 32'h40; #1;
    const_chk("bypass.same_cycle", {30'b0, pred_state}, 32'h2);
    @(negedge clk);
    upd_valid = 1'b0;
    m_tbl[6'h10] = 2'b10; m_mis = 1'b1; m_bcnt = m_bcnt + 1'b1; m_mcnt = m_mcnt + 1'b1;
    step("alias.0x140", 1'b1, 1'b0, 32'h0, 2'b01, 1'b0, 32'h140);
    const_chk("alias.pred", {30'b0, pred_state}, 32'h2);

    // Stall: mispredicting update held with en=0, then released once
    step("stall.arm", 1'b1, 1'b1, 32'h100, 2'b00, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++)
      step($sformatf("stall%0d", i), 1'b0, 1'b1, 32'h80, 2'b01, 1'b1, 32'h80);
    step("stall.release", 1'b1, 1'b1, 32'h80, 2'b01, 1'b1, 32'h84);
    step("stall.after", 1'b1, 1'b0, 32'h0, 2'b01, 1'b0, 32'h80);
    const_chk("stall.one_write", {30'b0, pred_state}, 32'h2);

    // Counter wrap on the 4-bit counters
    sync_reset();
    for (int i = 0; i < 17; i++)
      step($sformatf("wrap%0d", i), 1'b1, 1'b1, 32'(i * 4), 2'b00, 1'b1, 32'h200);
    const_chk("wrap.branch_cnt", {28'b0, branch_cnt}, 32'h1);
    const_chk("wrap.mispredict_cnt", {28'b0, mispredict_cnt}, 32'h1);

    // Asynchronous reset between edges while an update is pending
    @(negedge clk);
    en = 1'b1; upd_valid = 1'b1; upd_pc = 32'h40; upd_state = 2'b10; upd_taken = 1'b1;
    lookup_pc = 32'h40;
    #2;
    rst = 1'b1;
    #1;
    const_chk("arst.branch_cnt", {28'b0, branch_cnt}, 32'h0);
    const_chk("arst.mispredict_cnt", {28'b0, mispredict_cnt}, 32'h0);
    const_chk("arst.mispredict", {31'b0, mispredict}, 32'h0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    const_chk("arst.entry", {30'b0, pred_state}, 32'h1);
    step("arst.after", 1'b1, 1'b0, 32'h0, 2'b01, 1'b0, 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
